// File: rtl/cmu_uncached.sv
// cmu_uncached: CMU request responder for builds without a data cache.
// Every read or write turns into one single-beat Wishbone-style bus access.
// Byte-lane selection and sign or zero extension of read data happen here.
// Optional build macro: CMU_BUS_TIMEOUT_EN adds a bus-ack timeout that
// returns zero data, pulses bus_err and completes the request.
// Handshake: the requester holds en_r/en_w until it sees stall low. stall is
// high in the request cycle and for every bus cycle. The first cycle with
// stall low carries the completed result. While lock is high the result is
// held and the request is not issued again.
module cmu_uncached #(
   parameter int ADDR_BITS = 32,
   parameter int TIMEOUT   = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en_cache,
   input  logic [ADDR_BITS-1:0] addr_rw,
   input  logic [1:0]           addr_type,
   input  logic                 sign_ext,
   input  logic                 en_r,
   output logic [31:0]          data_r,
   input  logic                 en_w,
   input  logic [31:0]          data_w,
   input  logic                 en_f,
   input  logic                 lock,
   output logic                 stall,
   output logic                 wb_cyc,
   output logic                 wb_stb,
   output logic [ADDR_BITS-3:0] wb_addr,
   output logic [3:0]           wb_sel,
   output logic                 wb_we,
   output logic [31:0]          wb_dout,
   input  logic [31:0]          wb_din,
   input  logic                 wb_ack,
   output logic                 bus_err,
   output logic [1:0]           state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic        req;
   logic        tmo_hit;
   logic [1:0]  lat_off;
   logic [1:0]  lat_type;
   logic        lat_sext;
   logic [3:0]  sel_c;
   logic [31:0] dout_c;
   logic [15:0] rd_half;
   logic [7:0]  rd_byte;
   logic [31:0] rd_fmt;

   assign req = en_r | en_w;

   // Byte enables and replicated write data for the incoming request
   always_comb begin
      sel_c  = 4'b1111;
      dout_c = data_w;
      case (addr_type)
         2'd1: begin
            sel_c  = addr_rw[1] ? 4'b1100 : 4'b0011;
            dout_c = {2{data_w[15:0]}};
         end
         2'd2: begin
            sel_c  = 4'b0001 << addr_rw[1:0];
            dout_c = {4{data_w[7:0]}};
         end
         default: begin
            sel_c  = 4'b1111;
            dout_c = data_w;
         end
      endcase
   end

   // Lane pick and extension of bus read data using the latched request
   assign rd_half = lat_off[1] ? wb_din[31:16] : wb_din[15:0];
   assign rd_byte = wb_din[{lat_off, 3'b000} +: 8];

   always_comb begin
      rd_fmt = wb_din;
      case (lat_type)
         2'd1:    rd_fmt = {{16{lat_sext & rd_half[15]}}, rd_half};
         2'd2:    rd_fmt = {{24{lat_sext & rd_byte[7]}}, rd_byte};
         default: rd_fmt = wb_din;
      endcase
   end

`ifdef CMU_BUS_TIMEOUT_EN
   logic [7:0] tmo_cnt;

   assign tmo_hit = (tmo_cnt == 8'(TIMEOUT - 1));

   // Count bus cycles without ack; bus_err is a one-cycle pulse on expiry
   always_ff @(posedge clk) begin
      if (!rst) begin
         tmo_cnt <= '0;
         bus_err <= 1'b0;
      end else begin
         bus_err <= (state == S_BUS) && !wb_ack && tmo_hit;
         if (state == S_BUS) tmo_cnt <= tmo_cnt + 8'd1;
         else                tmo_cnt <= '0;
      end
   end

   logic unused_inputs;
   assign unused_inputs = ^{en_cache, en_f};
`else
   assign tmo_hit = 1'b0;
   assign bus_err = 1'b0;

   logic unused_inputs;
   assign unused_inputs = ^{en_cache, en_f, 8'(TIMEOUT)};
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic; ack wins over a timeout in the same cycle
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (req) state_nxt = S_BUS;
         S_BUS:   if (wb_ack || tmo_hit) state_nxt = S_DONE;
         S_DONE:  if (!(lock && req)) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Stall output; forced low while reset is asserted
   always_comb begin
      stall = 1'b0;
      case (state)
         S_IDLE:  stall = req;
         S_BUS:   stall = 1'b1;
         default: stall = 1'b0;
      endcase
      if (!rst) stall = 1'b0;
   end

   assign state_dbg = state;

   // Bus outputs, latched request fields and read data register
   always_ff @(posedge clk) begin
      if (!rst) begin
         wb_cyc   <= 1'b0;
         wb_stb   <= 1'b0;
         wb_we    <= 1'b0;
         wb_sel   <= '0;
         wb_addr  <= '0;
         wb_dout  <= '0;
         data_r   <= '0;
         lat_off  <= '0;
         lat_type <= '0;
         lat_sext <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req) begin
                  wb_cyc   <= 1'b1;
                  wb_stb   <= 1'b1;
                  wb_we    <= en_w;
                  wb_sel   <= sel_c;
                  wb_addr  <= addr_rw[ADDR_BITS-1:2];
                  wb_dout  <= dout_c;
                  lat_off  <= addr_rw[1:0];
                  lat_type <= addr_type;
                  lat_sext <= sign_ext;
               end
            end
            S_BUS: begin
               if (wb_ack) begin
                  wb_cyc <= 1'b0;
                  wb_stb <= 1'b0;
                  wb_we  <= 1'b0;
                  if (!wb_we) data_r <= rd_fmt;
               end else if (tmo_hit) begin
                  wb_cyc <= 1'b0;
                  wb_stb <= 1'b0;
                  wb_we  <= 1'b0;
                  data_r <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cmu_uncached.sv
// tb_cmu_uncached: directed and randomized checks of cmu_uncached against a
// behavioural model of lane selection, extension and request timing.
module tb_cmu_uncached;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en_cache = 1'b0;
   logic [31:0] addr_rw = '0;
   logic [1:0]  addr_type = '0;
   logic        sign_ext = 1'b0;
   logic        en_r = 1'b0;
   logic [31:0] data_r;
   logic        en_w = 1'b0;
   logic [31:0] data_w = '0;
   logic        en_f = 1'b0;
   logic        lock = 1'b0;
   logic        stall;
   logic        wb_cyc, wb_stb, wb_we;
   logic [29:0] wb_addr;
   logic [3:0]  wb_sel;
   logic [31:0] wb_dout;
   logic [31:0] wb_din = '0;
   logic        wb_ack = 1'b0;
   logic        bus_err;
   logic [1:0]  state_dbg;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] model_data_r = '0;
   logic [31:0] exp_q[$];

   cmu_uncached #(.ADDR_BITS(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .en_cache(en_cache), .addr_rw(addr_rw),
      .addr_type(addr_type), .sign_ext(sign_ext), .en_r(en_r),
      .data_r(data_r), .en_w(en_w), .data_w(data_w), .en_f(en_f),
      .lock(lock), .stall(stall), .wb_cyc(wb_cyc), .wb_stb(wb_stb),
      .wb_addr(wb_addr), .wb_sel(wb_sel), .wb_we(wb_we), .wb_dout(wb_dout),
      .wb_din(wb_din), .wb_ack(wb_ack), .bus_err(bus_err),
      .state_dbg(state_dbg)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   // ---------------- reference model ----------------
   function automatic int acc_size(input logic [1:0] t);
      if (t == 2'd1) return 2;
      if (t == 2'd2) return 1;
      return 4;
   endfunction

   function automatic int acc_off(input logic [31:0] a, input logic [1:0] t);
      int sz = acc_size(t);
      return (int'(a % 4) / sz) * sz;
   endfunction

   function automatic logic [3:0] model_sel(input logic [31:0] a, input logic [1:0] t);
      int sz = acc_size(t);
      int m  = (1 << sz) - 1;
      return 4'(m << acc_off(a, t));
   endfunction

   function automatic logic [31:0] model_dout(input logic [31:0] d, input logic [1:0] t);
      int sz = acc_size(t);
      if (sz == 2) return (d & 32'h0000FFFF) * 32'h00010001;
      if (sz == 1) return (d & 32'h000000FF) * 32'h01010101;
      return d;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] din, input logic [31:0] a,
                                               input logic [1:0] t, input bit sx);
      int sz = acc_size(t);
      logic [31:0] v    = din >> (8 * acc_off(a, t));
      logic [31:0] mask;
      if (sz == 4) return v;
      mask = (32'd1 << (8 * sz)) - 32'd1;
      v = v & mask;
      if (sx && ((v >> (8 * sz - 1)) & 32'd1) == 32'd1) v = v | ~mask;
      return v;
   endfunction

   // ---------------- driver ----------------
   task automatic do_access(input bit w, input bit r, input logic [31:0] a, input logic [1:0] t,
                            input bit sx, input logic [31:0] dw, input logic [31:0] din,
                            input int dly, input int hold);
      int  stall_cnt = 0;
      int  stb_cnt   = 0;
      bit  done      = 0;
      if (r && !w) model_data_r = model_read(din, a, t, sx);
      exp_q.push_back(model_data_r);
      @(negedge clk);
      en_w = w; en_r = r; addr_rw = a; addr_type = t; sign_ext = sx;
      data_w = dw; lock = (hold > 0); wb_din = din; en_f = 1'($urandom_range(0, 1));
      for (int c = 0; c < 64 && !done; c++) begin
         if (c > 0) begin
            @(negedge clk);
            wb_ack = 1'b0;
         end
         #1;
         if (stall) stall_cnt++;
         else done = 1;
         if (wb_stb) begin
            stb_cnt++;
            if (stb_cnt == 1) begin
               check("wb_addr", {2'b00, wb_addr}, a >> 2);
               check("wb_sel", {28'd0, wb_sel}, {28'd0, model_sel(a, t)});
               check("wb_we", {31'd0, wb_we}, {31'd0, w});
               if (w) check("wb_dout", wb_dout, model_dout(dw, t));
            end
            if (stb_cnt == dly + 1) wb_ack = 1'b1;
            // request fields must be ignored once the bus cycle is running
            addr_rw = $urandom; addr_type = 2'($urandom_range(0, 3));
            sign_ext = ~sx; data_w = $urandom;
         end
      end
      check("complete", {31'd0, done}, 32'd1);
      check("stall_cycles", stall_cnt, dly + 2);
      check("done_cyc", {31'd0, wb_cyc}, 32'd0);
      check("data_r", data_r, exp_q.pop_front());
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         #1;
         check("hold_stall", {31'd0, stall}, 32'd0);
         if (wb_stb) stb_cnt++;
      end
      check("stb_cycles", stb_cnt, dly + 1);
      @(negedge clk);
      en_r = 1'b0; en_w = 1'b0; lock = 1'b0; wb_ack = 1'b0; en_f = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_cyc"}, {31'd0, wb_cyc}, 32'd0);
      check({tag, "_stb"}, {31'd0, wb_stb}, 32'd0);
      check({tag, "_we"}, {31'd0, wb_we}, 32'd0);
      check({tag, "_sel"}, {28'd0, wb_sel}, 32'd0);
      check({tag, "_addr"}, {2'b00, wb_addr}, 32'd0);
      check({tag, "_dout"}, wb_dout, 32'd0);
      check({tag, "_data_r"}, data_r, 32'd0);
      check({tag, "_bus_err"}, {31'd0, bus_err}, 32'd0);
      check({tag, "_state"}, {30'd0, state_dbg}, 32'd0);
   endtask

   initial begin
      int k;
      bit w, r;
      int seen;
      // reset with a request pending: stall must stay low
      en_r = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_stall", {31'd0, stall}, 32'd0);
      check_all_zero("reset");
      en_r = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      // word read, ack in the third bus cycle
      do_access(0, 1, 32'h100, 2'd0, 0, 32'h0, 32'hDEADBEEF, 2, 0);
      // signed and unsigned byte read from lane 3
      do_access(0, 1, 32'h103, 2'd2, 1, 32'h0, 32'h80000000, 0, 0);
      do_access(0, 1, 32'h103, 2'd2, 0, 32'h0, 32'h80000000, 1, 0);
      // half write to the upper lanes; data_r must not move
      do_access(1, 0, 32'h202, 2'd1, 0, 32'h1234ABCD, 32'h55555555, 0, 0);
      // write and read together: write wins
      do_access(1, 1, 32'h207, 2'd0, 0, 32'hCAFEF00D, 32'h11111111, 1, 0);
      // lock hold for three cycles, then a fresh request
      do_access(0, 1, 32'h40A, 2'd1, 1, 32'h0, 32'h8001_7FFF, 0, 3);
      do_access(0, 1, 32'h40A, 2'd3, 0, 32'h0, 32'h0BADF00D, 0, 0);

      // flush alone: no stall, no bus traffic
      @(negedge clk);
      en_f = 1'b1;
      #1;
      check("flush_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      #1;
      check("flush_cyc", {31'd0, wb_cyc}, 32'd0);
      en_f = 1'b0;

      // randomized accesses
      for (int i = 0; i < 24; i++) begin
         k = $urandom_range(0, 2);
         w = (k != 0);
         r = (k != 1);
         do_access(w, r, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
      end

`ifdef CMU_BUS_TIMEOUT_EN
      // no ack: four bus cycles then a bus_err pulse with zero data
      @(negedge clk);
      en_r = 1'b1; addr_rw = 32'h10; addr_type = 2'd0; wb_din = 32'hFFFFFFFF;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (bus_err) break;
         if (wb_stb) seen++;
      end
      check("tmo_bus_err", {31'd0, bus_err}, 32'd1);
      check("tmo_bus_cycles", seen, 4);
      check("tmo_stall", {31'd0, stall}, 32'd0);
      check("tmo_data_r", data_r, 32'd0);
      check("tmo_cyc", {31'd0, wb_cyc}, 32'd0);
      model_data_r = '0;
      @(negedge clk);
      en_r = 1'b0;
      #1;
      check("tmo_pulse", {31'd0, bus_err}, 32'd0);
`endif

      // reset in the middle of a bus cycle
      @(negedge clk);
      en_r = 1'b1; addr_rw = 32'h300; addr_type = 2'd0;
      seen = 0;
      for (int c = 0; c < 10 && seen == 0; c++) begin
         @(negedge clk);
         #1;
         if (wb_cyc) seen = 1;
      end
      check("rst_bus_entered", seen, 1);
      rst = 1'b0;
      en_r = 1'b0;
      #1;
      check("rst_mid_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      #1;
      check_all_zero("mid_reset");
      model_data_r = '0;
      rst = 1'b1;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $finish;
   end

endmodule
